// File: rtl/op_sequencer.sv
// Command sequencer in front of the matrix controller.
// Queues host operation words, issues them one at a time on the controller
// operation bus, paces serial page transfers with host handshakes, and inserts
// the idle gap that lets back-to-back matrix multiplies present a fresh edge.
module op_sequencer #(
    parameter int unsigned Depth     = 8,
    parameter int unsigned MmCycles  = 528,
    parameter int unsigned XferWords = 64,
    parameter int unsigned CntW      = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_op_i,
    input  logic [31:0] host_wdata_i,
    input  logic        host_wvalid_i,
    output logic        host_wready_o,
    output logic [31:0] host_rdata_o,
    output logic        host_rvalid_o,
    input  logic        host_rready_i,
    output logic [31:0] operation_o,
    output logic        ctrl_enable_o,
    output logic [31:0] ctrl_in_data_o,
    input  logic [31:0] ctrl_out_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned Aw = $clog2(Depth);
    localparam logic [CntW-1:0] MmLast   = CntW'(MmCycles - 1);
    localparam logic [CntW-1:0] XferLast = CntW'(XferWords - 1);

    typedef enum logic [2:0] {
        StIdle,
        StMatmul,
        StGap,
        StWrite,
        StRead
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       op_q, op_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [31:0]       fifo_q [Depth];
    logic [Aw:0]       wr_ptr_q, rd_ptr_q;
    logic              full, empty, push, pop;
    logic [31:0]       head;

    assign full  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) &&
                   (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = enable_i && cmd_valid_i && !full;
    assign head  = fifo_q[rd_ptr_q[Aw-1:0]];

    assign cmd_ready_o = enable_i && !full;
    assign busy_o      = (state_q != StIdle) || !empty;
    assign operation_o = op_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

    // Command storage; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q[Aw-1:0]] <= cmd_op_i;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Sequencer state, hold counter, issued operation and status flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state decode and controller/host handshake outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        done_d         = 1'b0;
        err_d          = err_q;
        pop            = 1'b0;
        ctrl_enable_o  = 1'b0;
        ctrl_in_data_o = '0;
        host_wready_o  = 1'b0;
        host_rvalid_o  = 1'b0;
        host_rdata_o   = '0;

        unique case (state_q)
            StIdle: begin
                op_d = '0;
                if (!empty) begin
                    pop   = 1'b1;
                    cnt_d = '0;
                    case (head[3:0])
                        4'd0: done_d = 1'b1;
                        4'd1: begin
                            state_d = StMatmul;
                            op_d    = head;
                        end
                        4'd2: begin
                            state_d = StWrite;
                            op_d    = head;
                        end
                        4'd3: begin
                            state_d = StRead;
                            op_d    = head;
                        end
                        // Illegal opcodes are dropped, never driven on the bus.
                        default: begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
            StMatmul: begin
                ctrl_enable_o = 1'b1;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == MmLast) begin
                    done_d  = 1'b1;
                    op_d    = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                // Zero operation with the controller clocked so it sees the edge drop.
                ctrl_enable_o = 1'b1;
                state_d       = StIdle;
            end
            StWrite: begin
                host_wready_o  = 1'b1;
                ctrl_enable_o  = host_wvalid_i;
                ctrl_in_data_o = host_wdata_i;
                if (host_wvalid_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == XferLast) begin
                        done_d  = 1'b1;
                        op_d    = '0;
                        state_d = StIdle;
                    end
                end
            end
            StRead: begin
                host_rvalid_o = 1'b1;
                host_rdata_o  = ctrl_out_data_i;
                ctrl_enable_o = host_rready_i;
                if (host_rready_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == XferLast) begin
                        done_d  = 1'b1;
                        op_d    = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Global freeze: nothing advances and no handshake is offered.
        if (!enable_i) begin
            state_d       = state_q;
            cnt_d         = cnt_q;
            op_d          = op_q;
            done_d        = 1'b0;
            err_d         = err_q;
            pop           = 1'b0;
            ctrl_enable_o = 1'b0;
            host_wready_o = 1'b0;
            host_rvalid_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: stimulus pushes expected windows, done
// pulses and data words; negedge monitors pop and compare as the DUT presents them.
`timescale 1ns/1ps
module tb_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cmd_valid;
    logic [31:0] cmd_op;
    logic [31:0] host_wdata;
    logic        host_wvalid;
    logic        host_rready;
    logic [31:0] ctrl_out_data;
    logic        cmd_ready, host_wready, host_rvalid, ctrl_enable, busy, done, err;
    logic [31:0] host_rdata, operation, ctrl_in_data;

    op_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_op_i       (cmd_op),
        .host_wdata_i   (host_wdata),
        .host_wvalid_i  (host_wvalid),
        .host_wready_o  (host_wready),
        .host_rdata_o   (host_rdata),
        .host_rvalid_o  (host_rvalid),
        .host_rready_i  (host_rready),
        .operation_o    (operation),
        .ctrl_enable_o  (ctrl_enable),
        .ctrl_in_data_o (ctrl_in_data),
        .ctrl_out_data_i(ctrl_out_data),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        int          len;
        int          gap;   // -1: don't care
        int          off;   // cycles with ctrl_enable low inside a matmul window
    } win_t;

    win_t        exp_win[$];
    logic        exp_done[$];
    logic [31:0] exp_wr[$];
    logic [31:0] exp_rd[$];

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: got timeout/unexpected expected event at %0t", name, $time);
    endtask

    // ---------------- monitors ----------------
    logic [31:0] cur_op = '0;
    int          run = 0, off = 0, zero_run = 0, gap_before = 0;

    task automatic end_window(input logic [31:0] op_now);
        win_t w;
        if (exp_win.size() == 0) begin
            fail_now("win_unexpected");
        end else begin
            w = exp_win.pop_front();
            chk("win_op", cur_op, w.op);
            chk("win_len", 32'(run), 32'(w.len));
            if (w.gap >= 0) chk("win_gap", 32'(gap_before), 32'(w.gap));
            if (w.op[3:0] == 4'd1) begin
                chk("mm_ena_off", 32'(off), 32'(w.off));
                if (op_now == 32'd0) chk("gap_ena", {31'd0, ctrl_enable}, 32'd1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cur_op   = '0;
            run      = 0;
            off      = 0;
            zero_run = 0;
        end else begin
            // Operation windows.
            if (operation != cur_op) begin
                if (cur_op != 32'd0) end_window(operation);
                if (operation != 32'd0) begin
                    gap_before = zero_run;
                    run        = 0;
                    off        = 0;
                end
                cur_op   = operation;
                zero_run = 0;
            end
            if (cur_op != 32'd0) begin
                run++;
                if (!ctrl_enable) off++;
            end else begin
                zero_run++;
            end
            // Retirement.
            if (done) begin
                if (exp_done.size() == 0) fail_now("done_unexpected");
                else chk("done_err", {31'd0, err}, {31'd0, exp_done.pop_front()});
            end
            // Write path.
            if (host_wready) begin
                if (host_wvalid) begin
                    if (exp_wr.size() == 0) fail_now("wr_unexpected");
                    else chk("wr_data", ctrl_in_data, exp_wr.pop_front());
                    chk("wr_ena", {31'd0, ctrl_enable}, 32'd1);
                end else begin
                    chk("wr_stall_ena", {31'd0, ctrl_enable}, 32'd0);
                end
            end
            // Read path.
            if (host_rvalid) begin
                if (exp_rd.size() == 0) begin
                    fail_now("rd_unexpected");
                end else if (host_rready) begin
                    chk("rd_data", host_rdata, exp_rd.pop_front());
                    chk("rd_ena", {31'd0, ctrl_enable}, 32'd1);
                end else begin
                    chk("rd_stall_data", host_rdata, exp_rd[0]);
                    chk("rd_stall_ena", {31'd0, ctrl_enable}, 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] w, output int waited);
        logic rdy;
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_op    = w;
        forever begin
            @(negedge clk);
            rdy = cmd_ready;
            step();
            if (rdy) break;
            waited++;
            if (waited > 2000) begin
                fail_now("push_timeout");
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] w, input int len, input int gap, input int offc,
                         input logic e_err);
        int   n;
        win_t x;
        if (w[3:0] inside {4'd1, 4'd2, 4'd3}) begin
            x.op  = w;
            x.len = len;
            x.gap = gap;
            x.off = offc;
            exp_win.push_back(x);
        end
        exp_done.push_back(e_err);
        push_cmd(w, n);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy) begin
            step();
            n++;
            if (n > 3000) begin
                fail_now("idle_timeout");
                break;
            end
        end
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_operation"}, operation, 32'd0);
        chk({tag, "_ctrl_enable"}, {31'd0, ctrl_enable}, 32'd0);
        chk({tag, "_in_data"}, ctrl_in_data, 32'd0);
        chk({tag, "_wready"}, {31'd0, host_wready}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, host_rvalid}, 32'd0);
        chk({tag, "_rdata"}, host_rdata, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    // Toggled wvalid 1,0,1,...; optional reset asserted while word 30 is offered.
    task automatic write_page(input logic [31:0] base, input logic abort);
        int n = 0;
        while (!host_wready) begin
            step();
            n++;
            if (n > 3000) begin
                fail_now("wready_timeout");
                return;
            end
        end
        for (int j = 0; j < 127; j++) begin
            host_wvalid = (j % 2 == 0);
            host_wdata  = host_wvalid ? base + 32'(j / 2) : 32'hDEAD_0000 + 32'(j);
            if (abort && j == 60) begin
                #2 rst = 1'b1;
                #1 check_reset_outputs("abort");
                host_wvalid = 1'b0;
                step();
                step();
                rst = 1'b0;
                return;
            end
            if (host_wvalid) exp_wr.push_back(host_wdata);
            step();
        end
        host_wvalid = 1'b0;
    endtask

    // rready held low for 10 cycles after the 20th accept.
    task automatic read_page(input logic [31:0] base);
        int n = 0;
        int k = 0;
        int c = 0;
        while (!host_rvalid) begin
            step();
            n++;
            if (n > 3000) begin
                fail_now("rvalid_timeout");
                return;
            end
        end
        ctrl_out_data = base;
        exp_rd.push_back(base);
        while (k < 64 && c < 200) begin
            host_rready = !(c >= 20 && c < 30);
            step();
            if (host_rready) begin
                k++;
                if (k < 64) begin
                    ctrl_out_data = base + 32'(k);
                    exp_rd.push_back(ctrl_out_data);
                end
            end
            c++;
        end
        host_rready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [31:0] fill [8];
        fill = '{32'h00, 32'h07, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60};

        rst = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_op = '0;
        host_wdata = '0; host_wvalid = 1'b0; host_rready = 1'b0; ctrl_out_data = '0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        step();
        step();
        rst = 1'b0;

        // Single matrix multiply.
        issue(32'h0000_0C41, 528, -1, 0, 1'b0);
        wait_idle();
        chk("mm_idle_op", operation, 32'd0);

        // Back-to-back multiplies: exactly two zero cycles between windows.
        issue(32'h0000_0041, 528, -1, 0, 1'b0);
        issue(32'h0000_0141, 528, 2, 0, 1'b0);
        wait_idle();

        // Page write with toggled valid.
        issue(32'h0000_0052, 127, -1, 0, 1'b0);
        write_page(32'hA500_0000, 1'b0);
        wait_idle();

        // Page read with a 10-cycle ready stall.
        issue(32'h0000_0063, 74, -1, 0, 1'b0);
        read_page(32'hC000_0000);
        wait_idle();

        // Enable low for 5 cycles mid-multiply.
        issue(32'h0000_0241, 533, -1, 5, 1'b0);
        n = 0;
        while (operation != 32'h0000_0241 && n < 100) begin
            step();
            n++;
        end
        repeat (100) step();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("dis_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("dis_ctrl_enable", {31'd0, ctrl_enable}, 32'd0);
            chk("dis_operation", operation, 32'h0000_0241);
            step();
        end
        enable = 1'b1;
        wait_idle();

        // Fill the FIFO behind a running multiply.
        issue(32'h0000_0341, 528, -1, 0, 1'b0);
        step();
        step();
        for (int i = 0; i < 8; i++) issue(fill[i], 0, -1, 0, (i != 0));
        chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        exp_done.push_back(1'b1);
        push_cmd(32'h0000_00F0, n);
        chk("full_wait_long", {31'd0, n > 400}, 32'd1);
        wait_idle();
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Reset mid-write with a NOP still queued: neither may retire.
        push_cmd(32'h0000_0052, n);
        push_cmd(32'h0000_0000, n);
        write_page(32'h5500_0000, 1'b1);
        repeat (3) step();
        chk("post_abort_busy", {31'd0, busy}, 32'd0);
        chk("post_abort_err", {31'd0, err}, 32'd0);

        // Next command restarts the transfer from word 0.
        issue(32'h0000_0052, 127, -1, 0, 1'b0);
        write_page(32'h5A00_0000, 1'b0);
        wait_idle();
        repeat (3) step();

        chk("left_win", 32'(exp_win.size()), 32'd0);
        chk("left_done", 32'(exp_done.size()), 32'd0);
        chk("left_wr", 32'(exp_wr.size()), 32'd0);
        chk("left_rd", 32'(exp_rd.size()), 32'd0);
        chk("final_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
